// File: rtl/debug_cmd_engine.sv
// debug_cmd_engine: virtual-JTAG scan register with one-hot command hand-off; DEBUG_CMD_ENGINE_TIMEOUT_EN enables the pending-command timeout
module debug_cmd_engine #(
  parameter int SR_W        = 38,
  parameter int DATA_W      = 32,
  parameter int IR_W        = 2,
  parameter int NCH         = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vs_cdr,
  input  logic                   vs_sdr,
  input  logic                   vs_udr,
  input  logic                   vs_uir,
  input  logic [IR_W-1:0]        ir_in,
  input  logic                   tdi,
  output logic                   tdo,
  input  logic [NCH*DATA_W-1:0]  cap_data,
  input  logic [SR_W-DATA_W-1:0] cap_status,
  output logic [SR_W-1:0]        jdo,
  output logic [NCH-1:0]         take_action,
  output logic [NCH-1:0]         take_no_action,
  input  logic                   cmd_ack,
  output logic                   busy,
  output logic                   overrun,
  output logic                   timeout
);
  localparam int NI = 2**IR_W;
  typedef enum logic {IDLE, SHIFT} state_t;
  if (SR_W <= DATA_W || NCH > NI || NCH < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("debug_cmd_engine: illegal parameter combination");
  end
  state_t            state_q;
  logic [SR_W-1:0]   sr_q, jdo_q;
  logic [IR_W-1:0]   ir_q;
  logic              tdo_q, busy_q, ovr_q, to_q;
  logic [NCH-1:0]    act_q, nact_q;
  logic [NI-1:0]     ok, oh;
  logic [DATA_W-1:0] cap_w;
  logic              expire, retire, udr_sh, accept;
  // channel decode: which instructions map to a real channel, and the captured word
  always_comb begin
    ok = '0;
    for (int i = 0; i < NCH; i++) ok[i] = 1'b1;
    oh = NI'(1) << ir_q;
    cap_w = ok[ir_q] ? cap_data[ir_q*DATA_W +: DATA_W] : '0;
  end
`ifdef DEBUG_CMD_ENGINE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q;
  // counts cycles a command has been pending; restarts whenever busy drops
  always_ff @(posedge clk) cnt_q <= (reset || !busy_q || retire) ? '0 : cnt_q + 1'b1;
  assign expire = busy_q && cnt_q == CW'(TIMEOUT_CYC - 1);
`else
  assign expire = 1'b0;
`endif
  // an ack (or expiry) retires the old command first so a same-cycle update is accepted
  assign retire = busy_q && (cmd_ack || expire);
  assign udr_sh = vs_udr && !vs_uir && state_q == SHIFT;
  assign accept = udr_sh && (!busy_q || retire);
  // scan FSM, shift register and command outputs, all registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      jdo_q   <= '0;
      ir_q    <= '0;
      tdo_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
      act_q   <= '0;
      nact_q  <= '0;
    end else begin
      state_q <= (vs_uir || vs_udr) ? IDLE : vs_cdr ? SHIFT : state_q;
      if (vs_uir) ir_q <= ir_in;
      ovr_q <= !vs_uir && (ovr_q || (udr_sh && !accept));
      to_q  <= !vs_uir && (to_q || (expire && !cmd_ack));
      if (!vs_uir && !vs_udr && vs_cdr) sr_q <= {cap_status, cap_w};
      else if (!vs_uir && !vs_udr && vs_sdr && state_q == SHIFT) begin
        sr_q  <= {tdi, sr_q[SR_W-1:1]};
        tdo_q <= sr_q[0];
      end
      if (accept) jdo_q <= sr_q;
      if (accept && ok[ir_q]) begin
        busy_q <= 1'b1;
        act_q  <= sr_q[SR_W-1] ? oh[NCH-1:0] : '0;
        nact_q <= sr_q[SR_W-1] ? '0 : oh[NCH-1:0];
      end else if (retire) begin
        busy_q <= 1'b0;
        act_q  <= '0;
        nact_q <= '0;
      end
    end
  end
  assign tdo            = tdo_q;
  assign jdo            = jdo_q;
  assign take_action    = act_q;
  assign take_no_action = nact_q;
  assign busy           = busy_q;
  assign overrun        = ovr_q;
  assign timeout        = to_q;
endmodule

// File: doc/debug_cmd_engine.md
DEBUG_CMD_ENGINE -- requirements
Module: debug_cmd_engine

Interface
REQ-001 Parameters SHALL be: SR_W, 38, scan register width; DATA_W, 32, capture data width (SR_W > DATA_W); IR_W, 2, instruction width; NCH, 4, channel count (NCH <= 2**IR_W); TIMEOUT_CYC, 1024, pending timeout in clk cycles.
REQ-002 The module SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- vs_cdr, vs_sdr, vs_udr, vs_uir  in  1 each  single-cycle capture-DR, shift-DR, update-DR and update-IR strobes, already synchronised to clk.
- ir_in  in  IR_W  virtual instruction.
- tdi  in  1  serial data in.
- tdo  out  1  serial data out.
- cap_data  in  NCH*DATA_W  per-channel capture words; channel k occupies bits [k*DATA_W +: DATA_W].
- cap_status  in  SR_W-DATA_W  status bits captured into the SR upper field.
- jdo  out  SR_W  latched scan word.
- take_action  out  NCH  one-hot command, action bit set.
- take_no_action  out  NCH  one-hot command, action bit clear.
- cmd_ack  in  1  consumer accepts the pending command.
- busy  out  1  command pending.
- overrun  out  1  sticky: update dropped.
- timeout  out  1  sticky: pending expired (REQ-017).

Function
REQ-004 On vs_uir, ir_q SHALL load ir_in.
REQ-005 States SHALL be IDLE and SHIFT. IDLE goes to SHIFT on vs_cdr. SHIFT goes to IDLE on vs_udr or vs_uir. SHIFT stays in SHIFT on vs_cdr (re-capture).
REQ-006 On vs_cdr the SR SHALL load cap_status in the upper field and, in the lower field, channel ir_q of cap_data if ir_q < NCH, else zero.
REQ-007 On vs_sdr in SHIFT, the SR SHALL become {tdi, sr[SR_W-1:1]}, and tdo SHALL take the pre-shift sr[0] in the same edge.
- vs_sdr in IDLE has no effect.
REQ-008 On vs_udr in SHIFT with busy low:
- jdo SHALL load the SR.
- On the next cycle, with ir_q < NCH, busy SHALL go high, together with take_action[ir_q] if sr[SR_W-1]=1, else take_no_action[ir_q].
- ir_q >= NCH: jdo updates and no command is raised.
REQ-009 take_action / take_no_action and busy SHALL hold until the first cycle cmd_ack=1. They clear on the next edge, so a single-cycle ack completes the command. cmd_ack while busy is low SHALL be ignored.
REQ-010 On vs_udr while busy: jdo SHALL be unchanged, the command SHALL be dropped, and overrun SHALL set. Capture and shift stay operational while busy.
REQ-011 overrun and timeout SHALL clear on vs_uir or reset only.
REQ-012 Strobe priority in one cycle SHALL be vs_uir > vs_udr > vs_cdr > vs_sdr; only the highest-priority strobe acts. cmd_ack in the same cycle as vs_udr SHALL retire the old command first, so the new update is accepted without overrun.
REQ-013 At most one bit of take_action | take_no_action SHALL ever be high.

Reset
REQ-014 On reset: state=IDLE; sr, ir_q and jdo all zero; tdo, busy, overrun and timeout 0; take_action and take_no_action all zero.
REQ-015 Reset SHALL override every strobe and cmd_ack in the same cycle, including mid-shift and while a command is pending (the command is discarded).

Configuration
REQ-016 The macro DEBUG_CMD_ENGINE_TIMEOUT_EN SHALL gate the pending-timeout counter.
REQ-017 With the macro defined, a counter SHALL count cycles with busy high. When it reaches TIMEOUT_CYC, busy and the command outputs SHALL clear and timeout SHALL set. The counter SHALL reset whenever busy is low.
REQ-018 Without the macro, no counter logic SHALL exist, timeout SHALL be tied 0, and a command SHALL stay pending until cmd_ack.

Verification (SR_W=38, DATA_W=32, NCH=4)
REQ-019 Capture: ir_in=2, then vs_uir; cap_data ch2=0xDEADBEEF, cap_status=6'h15; vs_cdr, then 38 vs_sdr with tdi=0 -> tdo sequence equals 0xDEADBEEF LSB-first, then 1,0,1,0,1,0.
REQ-020 Command: shift in 38'h20_0000_00A5, ir_q=1, vs_udr -> jdo=38'h20_0000_00A5, take_action=4'b0010 and busy=1 one cycle later; cmd_ack pulse -> both clear on the next edge.
REQ-021 Overrun: command pending and no ack; second vs_udr -> jdo unchanged, overrun=1; vs_uir -> overrun=0.
REQ-022 Simultaneous: cmd_ack and vs_udr in the same cycle -> new command raised, overrun stays 0; vs_uir and vs_udr together -> only ir_q loads.
REQ-023 Reset mid-operation: reset after 17 shifts with a command pending -> all outputs at REQ-014 values the next cycle.
REQ-024 With DEBUG_CMD_ENGINE_TIMEOUT_EN and TIMEOUT_CYC=8: no ack -> busy clears and timeout=1 after exactly 8 busy cycles. Without the macro, busy still =1 after 100 cycles.
